mux_logic_sweeper: RTL

Sequential stimulus-and-capture stage that sits directly upstream of the 2:1-mux logic block (inputs a, b, c; output y).

- On a start pulse it drives all 8 combinations of {a,b,c} in ascending order.
- It holds each vector for a programmable settle time, then samples the returned y.
- It builds an 8-bit observed truth table and compares it against a golden table latched at start.
- It reports done, pass and mismatch diagnostics to the Python testbench layer.

---
 rtl/mux_logic_sweeper.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mux_logic_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : mux_logic_sweeper
// Purpose  : Drives all 8 {a,b,c} vectors into a 2:1-mux logic block, samples
//            y after a settle time and compares the observed table to golden.
// Revision : 1.0
// ============================================================================
module mux_logic_sweeper #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] golden,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       c_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] result,
   output logic [2:0] mismatch_idx,
   output logic [3:0] mismatch_cnt
);

   // A settle time of zero would sample before the stimulus is ever driven.
   localparam int             c_SETTLE   = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(c_SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t           r_state;
   logic [2:0]       r_vec;
   logic [2:0]       r_stim;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_gold;
   logic [7:0]       r_result;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [2:0]       r_midx;
   logic [3:0]       r_mcnt;

   logic             w_miss;
   logic [3:0]       w_mcnt_nxt;

   assign w_miss     = (y_in != r_gold[r_vec]);
   assign w_mcnt_nxt = r_mcnt + {3'd0, w_miss};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_vec    <= 3'd0;
         r_stim   <= 3'd0;
         r_cnt    <= '0;
         r_gold   <= 8'd0;
         r_result <= 8'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_midx   <= 3'd0;
         r_mcnt   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_vec    <= 3'd0;
                  r_stim   <= 3'd0;
                  r_cnt    <= '0;
                  r_gold   <= golden;
                  r_result <= 8'd0;
                  r_pass   <= 1'b0;
                  r_midx   <= 3'd0;
                  r_mcnt   <= 4'd0;
                  r_busy   <= 1'b1;
                  r_state  <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == c_CNT_LAST) begin
                  r_state <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               r_result[r_vec] <= y_in;
               if (w_miss) begin
                  r_mcnt <= w_mcnt_nxt;
                  if (r_mcnt == 4'd0) begin
                     r_midx <= r_vec;
                  end
               end
               if (r_vec == 3'd7) begin
                  // pass must reflect this final sample, so use the next count
                  r_pass  <= (w_mcnt_nxt == 4'd0);
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_stim  <= 3'd0;
                  r_state <= S_FINISH;
               end else begin
                  r_vec   <= r_vec + 3'd1;
                  r_stim  <= r_vec + 3'd1;
                  r_cnt   <= '0;
                  r_state <= S_DRIVE;
               end
            end
            S_FINISH: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign {a_out, b_out, c_out} = r_stim;
   assign busy         = r_busy;
   assign done         = r_done;
   assign pass         = r_pass;
   assign result       = r_result;
   assign mismatch_idx = r_midx;
   assign mismatch_cnt = r_mcnt;

endmodule
`default_nettype wire
